adder_result_fifo: RTL and testbench

- Downstream stage of the registered 4-bit adder. Captures each {Overflow, Sum} result the adder produces and queues it in a small first-word-fall-through FIFO.
- Presents queued results to the next consumer over a valid/ready handshake. Reports occupancy, and flags results lost because the FIFO was full.
- Shares the adder's Clk and En. Sum and Overflow are wired directly from the adder outputs.

---
 rtl/adder_result_fifo.sv | 99 +++++++++
 tb/tb_adder_result_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/adder_result_fifo.sv
// Result FIFO behind the registered 4-bit adder: captures {Overflow, Sum} one cycle after En
// and presents entries first-word-fall-through over valid/ready. Optional macro: ADDER_OVF_COUNT_EN.
module adder_result_fifo #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              En,
  input  logic [WIDTH-1:0]  Sum,
  input  logic              Overflow,
  input  logic              Out_Ready,
  output logic              Out_Valid,
  output logic [WIDTH-1:0]  Out_Data,
  output logic              Out_Ovf,
  output logic              Full,
  output logic              Empty,
  output logic [ADDR_W:0]   Count,
  output logic              Drop,
  output logic [7:0]        Ovf_Count
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH:0]    mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              pend_q;
  logic              drop_q, drop_d;
  logic              push, pop;
  logic [WIDTH:0]    head;

  assign Empty     = (count_q == '0);
  assign Full      = (count_q == FULL_CNT);
  assign Out_Valid = !Empty;
  assign Count     = count_q;
  assign Drop      = drop_q;
  assign head      = mem_q[rd_ptr_q];
  assign Out_Data  = Empty ? '0 : head[WIDTH-1:0];
  assign Out_Ovf   = Empty ? 1'b0 : head[WIDTH];

  // A full FIFO can still accept a pending result when the head leaves in the same cycle.
  always_comb begin
    pop      = Out_Valid && Out_Ready;
    push     = pend_q && (!Full || pop);
    drop_d   = pend_q && Full && !pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pend_q   <= En;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= {Overflow, Sum};
  end

`ifdef ADDER_OVF_COUNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (push && Overflow && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + 8'd1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) ovf_cnt_q <= '0;
    else        ovf_cnt_q <= ovf_cnt_d;
  end

  assign Ovf_Count = ovf_cnt_q;
`else
  assign Ovf_Count = '0;
`endif

endmodule

// File: tb/tb_adder_result_fifo.sv
// Directed bench for adder_result_fifo, driven by a small registered adder model.
module tb_adder_result_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic [3:0] sum = '0;
  logic       ovf = 1'b0;
  logic       ready = 1'b0;

  logic       out_valid, out_ovf, full, empty, drop;
  logic [3:0] out_data;
  logic [2:0] count;
  logic [7:0] ovf_count;

  int checks = 0;
  int fails  = 0;

`ifdef ADDER_OVF_COUNT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  // Upstream registered adder: updates Sum/Overflow on edges where En is high.
  always @(posedge clk) if (en) {ovf, sum} <= a + b;

  adder_result_fifo #(.WIDTH(4), .DEPTH(4), .ADDR_W(2)) dut (
    .Clk(clk), .Rst_n(rst_n), .En(en), .Sum(sum), .Overflow(ovf),
    .Out_Ready(ready), .Out_Valid(out_valid), .Out_Data(out_data), .Out_Ovf(out_ovf),
    .Full(full), .Empty(empty), .Count(count), .Drop(drop), .Ovf_Count(ovf_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"},  32'(full), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_data"},  32'(out_data), 0);
    chk({tag, "_ovf"},   32'(out_ovf), 0);
    chk({tag, "_drop"},  32'(drop), 0);
  endtask

  int exp_head [12] = '{1, 2, 3, 4, 6, 7, 8, 9, 10, 11, 12, 13};

  initial begin
    // Reset state
    tick(); tick();
    chk_idle("rst");
    chk("rst_ovfcnt", 32'(ovf_count), 0);
    rst_n = 1'b1;
    tick();

    // Single result 3+4
    a = 4'd3; b = 4'd4; en = 1'b1; tick();
    chk("single_lat_valid", 32'(out_valid), 0);
    en = 1'b0; tick();
    chk("single_valid", 32'(out_valid), 1);
    chk("single_data",  32'(out_data), 7);
    chk("single_ovf",   32'(out_ovf), 0);
    chk("single_count", 32'(count), 1);
    ready = 1'b1; tick(); ready = 1'b0;
    chk("single_pop_empty", 32'(empty), 1);

    // Overflow path 9+8 = 17 -> sum 1, carry 1
    a = 4'd9; b = 4'd8; en = 1'b1; tick();
    en = 1'b0; tick();
    chk("ovf_data",   32'(out_data), 1);
    chk("ovf_bit",    32'(out_ovf), 1);
    chk("ovf_count",  32'(count), 1);
    chk("ovf_ovfcnt", 32'(ovf_count), OVF_EN ? 1 : 0);
    ready = 1'b1; tick(); ready = 1'b0;
    chk("ovf_pop_empty", 32'(empty), 1);

    // Fill with 1..5, fifth result dropped
    b = 4'd0; en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      a = 4'(k); tick();
      chk("fill_drop_low", 32'(drop), 0);
    end
    chk("fill_count", 32'(count), 4);
    chk("fill_full",  32'(full), 1);
    en = 1'b0; tick();
    chk("drop_pulse", 32'(drop), 1);
    chk("drop_count", 32'(count), 4);
    chk("drop_head",  32'(out_data), 1);
    tick();
    chk("drop_one_cycle", 32'(drop), 0);
    ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_data", 32'(out_data), 32'(k));
      tick();
    end
    ready = 1'b0;
    chk_idle("drain");

    // Refill to full with 1..4, then stream 6..13 through while full
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      a = 4'(k); tick();
    end
    en = 1'b0; tick();
    chk("refill_full", 32'(full), 1);
    a = 4'd6; en = 1'b1; tick();
    ready = 1'b1;
    for (int k = 7; k <= 14; k++) begin
      if (k <= 13) a = 4'(k);
      else en = 1'b0;
      chk("stream_head", 32'(out_data), 32'(exp_head[k - 7]));
      tick();
      chk("stream_count", 32'(count), 4);
      chk("stream_full",  32'(full), 1);
      chk("stream_drop",  32'(drop), 0);
    end
    for (int i = 8; i < 12; i++) begin
      chk("wrap_drain", 32'(out_data), 32'(exp_head[i]));
      tick();
    end
    ready = 1'b0;
    chk_idle("wrap_end");

    // Asynchronous reset mid-stream with Count=3 and a capture pending
    en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      a = 4'(k); tick();
    end
    en = 1'b0; tick();
    chk("pre_rst_count", 32'(count), 3);
    a = 4'd5; en = 1'b1; tick();
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_ovfcnt", 32'(ovf_count), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_no_pend", 32'(count), 0);
    a = 4'd3; b = 4'd4; en = 1'b1; tick();
    en = 1'b0; tick();
    chk("post_rst_count", 32'(count), 1);
    chk("post_rst_data",  32'(out_data), 7);

    // Overflow counter saturation: 8+8 carries out every time
    a = 4'd8; b = 4'd8; ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    en = 1'b0; tick();
    chk("sat_100", 32'(ovf_count), OVF_EN ? 100 : 0);
    en = 1'b1;
    for (int i = 0; i < 200; i++) tick();
    en = 1'b0; tick();
    chk("sat_300", 32'(ovf_count), OVF_EN ? 255 : 0);
    en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    en = 1'b0; tick(); tick();
    chk("sat_hold", 32'(ovf_count), OVF_EN ? 255 : 0);
    chk("sat_empty", 32'(empty), 1);
    chk("sat_drop",  32'(drop), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
